// File: rtl/cnn_quad_job_master_if.sv
// -----------------------------------------------------------------------------
// cnn_quad_job_master_if
// Bundles every handshake and data signal between the job master, the host
// command/result ports, the DMA fetch control and the quad job/result port.
//
// Modports:
//   master : the job master's view (drives cmd_ready, job_*, fetch_go,
//            result_accept, res_*, done, err_*)
//   slave  : the environment's view (host, DMA and quad together)
// -----------------------------------------------------------------------------
interface cnn_quad_job_master_if #(
    parameter int C_RESULT_WIDTH = 16
);
    // host command port
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [127:0]              cmd_params;
    logic [31:0]               cmd_num_results;
    // quad job handshake
    logic                      job_start;
    logic                      job_accept;
    logic [127:0]              job_parameters;
    logic                      job_fetch_request;
    logic                      job_fetch_ack;
    logic                      job_fetch_complete;
    logic                      job_complete;
    logic                      job_complete_ack;
    // DMA control
    logic                      fetch_go;
    logic                      fetch_done;
    // quad result stream
    logic                      result_valid;
    logic                      result_accept;
    logic [C_RESULT_WIDTH-1:0] result_data;
    // host result stream and status
    logic                      res_valid;
    logic                      res_ready;
    logic [C_RESULT_WIDTH-1:0] res_data;
    logic                      done;
    logic                      err_timeout;
    logic                      err_overrun;

    modport master (
        input  cmd_valid, cmd_params, cmd_num_results,
        input  job_accept, job_fetch_request, job_complete,
        input  fetch_done, result_valid, result_data, res_ready,
        output cmd_ready, job_start, job_parameters, job_fetch_ack,
        output job_fetch_complete, job_complete_ack, fetch_go,
        output result_accept, res_valid, res_data, done,
        output err_timeout, err_overrun
    );

    modport slave (
        output cmd_valid, cmd_params, cmd_num_results,
        output job_accept, job_fetch_request, job_complete,
        output fetch_done, result_valid, result_data, res_ready,
        input  cmd_ready, job_start, job_parameters, job_fetch_ack,
        input  job_fetch_complete, job_complete_ack, fetch_go,
        input  result_accept, res_valid, res_data, done,
        input  err_timeout, err_overrun
    );
endinterface

// File: rtl/cnn_quad_job_master.sv
// -----------------------------------------------------------------------------
// cnn_quad_job_master
// Initiator for the quad job/result protocol. Takes one host descriptor at a
// time, runs start/accept, one or more fetch request/ack/complete episodes and
// the complete/ack handshake, while forwarding quad results to the host
// through a 2-entry skid buffer and counting them against the job target.
//
// Ports:
//   clk_if : interface clock
//   rst    : asynchronous reset, active low
//   bus    : cnn_quad_job_master_if.master (host cmd, quad job, DMA control,
//            result streams, done/error status)
// -----------------------------------------------------------------------------
module cnn_quad_job_master #(
    parameter int C_RESULT_WIDTH   = 16,
    parameter int C_ACCEPT_TIMEOUT = 1024
) (
    input  logic                         clk_if,
    input  logic                         rst,
    cnn_quad_job_master_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH_WAIT,
        S_FETCH,
        S_RUN,
        S_DONE
    } state_t;

    // Timer value in the last START cycle before giving up.
    localparam logic [31:0] LP_TIMEOUT_LAST = 32'(C_ACCEPT_TIMEOUT - 1);
    localparam logic        LP_TIMEOUT_EN   = (C_ACCEPT_TIMEOUT != 0);

    state_t                    r_state;
    state_t                    w_state_next;

    logic [127:0]              r_job_parameters;
    logic [31:0]               r_res_target;
    logic [31:0]               r_res_cnt;
    logic [31:0]               r_acc_timer;
    logic                      r_err_timeout;
    logic                      r_err_overrun;
    logic                      r_fetch_ack;
    logic                      r_fetch_complete;
    logic                      r_complete_ack;

    logic                      w_cmd_take;
    logic                      w_timeout_hit;
    logic                      w_fetch_ack_next;
    logic                      w_fetch_complete_next;
    logic                      w_complete_ack_next;

    // skid buffer
    logic [C_RESULT_WIDTH-1:0] r_head;
    logic [C_RESULT_WIDTH-1:0] r_tail;
    logic [1:0]                r_count;
    logic                      r_result_accept;
    logic [1:0]                w_count_next;
    logic                      w_push;
    logic                      w_pop;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_fetch_ack      <= 1'b0;
            r_fetch_complete <= 1'b0;
            r_complete_ack   <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_fetch_ack      <= w_fetch_ack_next;
            r_fetch_complete <= w_fetch_complete_next;
            r_complete_ack   <= w_complete_ack_next;
        end
    end

    always_comb begin
        w_state_next          = r_state;
        w_cmd_take            = 1'b0;
        w_timeout_hit         = 1'b0;
        w_fetch_ack_next      = 1'b0;
        w_fetch_complete_next = 1'b0;
        w_complete_ack_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_cmd_take   = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (bus.job_accept) begin
                    w_state_next = S_FETCH_WAIT;
                end else if (LP_TIMEOUT_EN && (r_acc_timer == LP_TIMEOUT_LAST)) begin
                    // Abort goes through DONE so the done pulse and the
                    // return of cmd_ready look the same as a normal finish.
                    w_timeout_hit = 1'b1;
                    w_state_next  = S_DONE;
                end
            end
            S_FETCH_WAIT: begin
                if (bus.job_fetch_request) begin
                    w_fetch_ack_next = 1'b1;
                    w_state_next     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.fetch_done) begin
                    w_fetch_complete_next = 1'b1;
                    w_state_next          = S_RUN;
                end
            end
            S_RUN: begin
                // A new fetch request wins over a simultaneous job_complete;
                // the complete level is re-examined after that fetch ends.
                if (bus.job_fetch_request) begin
                    w_fetch_ack_next = 1'b1;
                    w_state_next     = S_FETCH;
                end else if (bus.job_complete && (r_res_cnt >= r_res_target) &&
                             (r_count == 2'd0)) begin
                    w_complete_ack_next = 1'b1;
                    w_state_next        = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Job registers, accept timer and status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            r_job_parameters <= '0;
            r_res_target     <= '0;
            r_acc_timer      <= '0;
            r_err_timeout    <= 1'b0;
        end else begin
            if (w_cmd_take) begin
                r_job_parameters <= bus.cmd_params;
                r_res_target     <= bus.cmd_num_results;
                r_acc_timer      <= '0;
                r_err_timeout    <= 1'b0;
            end else begin
                if ((r_state == S_START) && (r_acc_timer != '1)) begin
                    r_acc_timer <= r_acc_timer + 32'd1;
                end
                if (w_timeout_hit) begin
                    r_err_timeout <= 1'b1;
                end
            end
        end
    end

    // Result counter keeps running in IDLE so late words of a finished job
    // are still flagged as overrun.
    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            r_res_cnt     <= '0;
            r_err_overrun <= 1'b0;
        end else if (w_cmd_take) begin
            r_res_cnt     <= '0;
            r_err_overrun <= 1'b0;
        end else if (w_push) begin
            if (r_res_cnt == r_res_target) begin
                r_err_overrun <= 1'b1;
            end
            if (r_res_cnt != '1) begin
                r_res_cnt <= r_res_cnt + 32'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // 2-entry skid buffer: head feeds the host, tail catches the word that
    // arrives while the head is stalled.
    // -------------------------------------------------------------------------
    assign w_push       = bus.result_valid & r_result_accept;
    assign w_pop        = (r_count != 2'd0) & bus.res_ready;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= 2'd0;
            r_result_accept <= 1'b0;
        end else begin
            r_count         <= w_count_next;
            r_result_accept <= (w_count_next != 2'd2);
            if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
                r_head <= bus.result_data;
            end else if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end
            if (w_push && (r_count == 2'd1) && !w_pop) begin
                r_tail <= bus.result_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.cmd_ready          = (r_state == S_IDLE);
    assign bus.job_start          = (r_state == S_START);
    assign bus.done               = (r_state == S_DONE);
    assign bus.job_parameters     = r_job_parameters;
    assign bus.job_fetch_ack      = r_fetch_ack;
    assign bus.fetch_go           = r_fetch_ack;
    assign bus.job_fetch_complete = r_fetch_complete;
    assign bus.job_complete_ack   = r_complete_ack;
    assign bus.result_accept      = r_result_accept;
    assign bus.res_valid          = (r_count != 2'd0);
    assign bus.res_data           = r_head;
    assign bus.err_timeout        = r_err_timeout;
    assign bus.err_overrun        = r_err_overrun;

endmodule

// File: tb/tb_cnn_quad_job_master.sv
// -----------------------------------------------------------------------------
// tb_cnn_quad_job_master
// Directed bench for cnn_quad_job_master: nominal job, result backpressure,
// accept timeout, overrun, multi-fetch with fetch/complete collision, zero
// result job and asynchronous reset in the middle of a fetch.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there or on the falling edge.
// -----------------------------------------------------------------------------
module tb_cnn_quad_job_master;

    localparam int W_CACK  = 0;
    localparam int W_DONE  = 1;
    localparam int W_READY = 2;

    logic clk_if;
    logic rst;

    cnn_quad_job_master_if #(.C_RESULT_WIDTH(16)) bus();

    cnn_quad_job_master #(
        .C_RESULT_WIDTH   (16),
        .C_ACCEPT_TIMEOUT (8)
    ) dut (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus)
    );

    initial begin
        clk_if = 1'b0;
        forever #5 clk_if = ~clk_if;
    end

    // event counters and result collector (falling edge)
    int          n_start, n_ack, n_go, n_fcpl, n_cack, n_done, ack_words;
    logic [15:0] got_q[$];

    initial begin
        n_start = 0; n_ack = 0; n_go = 0; n_fcpl = 0;
        n_cack = 0; n_done = 0; ack_words = 0;
    end

    always @(negedge clk_if) begin
        if (bus.job_start)          n_start++;
        if (bus.job_fetch_ack)      n_ack++;
        if (bus.fetch_go)           n_go++;
        if (bus.job_fetch_complete) n_fcpl++;
        if (bus.job_complete_ack) begin
            n_cack++;
            ack_words = got_q.size();
        end
        if (bus.done)               n_done++;
        if (rst && bus.res_valid && bus.res_ready) got_q.push_back(bus.res_data);
    end

    int n_cmp;
    int n_err;
    int s_start, s_ack, s_go, s_fcpl, s_cack, s_done, s_idx;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    task automatic snap();
        s_start = n_start; s_ack = n_ack; s_go = n_go; s_fcpl = n_fcpl;
        s_cack = n_cack; s_done = n_done; s_idx = got_q.size();
    endtask

    task automatic wait_for(input int sel, input string tag);
        int   k;
        logic hit;
        k = 0;
        forever begin
            case (sel)
                W_CACK:  hit = bus.job_complete_ack;
                W_DONE:  hit = bus.done;
                W_READY: hit = bus.cmd_ready;
                default: hit = 1'b1;
            endcase
            if (hit || (k >= 200)) break;
            tick();
            k++;
        end
        chk(tag, 128'(hit), 128'd1);
    endtask

    task automatic send_cmd(input logic [127:0] p, input logic [31:0] n);
        wait_for(W_READY, "cmd_ready_wait");
        bus.cmd_valid       = 1'b1;
        bus.cmd_params      = p;
        bus.cmd_num_results = n;
        tick();
        bus.cmd_valid       = 1'b0;
    endtask

    task automatic accept_now();
        bus.job_accept = 1'b1;
        tick();
        bus.job_accept = 1'b0;
    endtask

    task automatic inject(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            int k;
            bus.result_valid = 1'b1;
            bus.result_data  = first + 16'(i);
            k = 0;
            while (!bus.result_accept && (k < 64)) begin
                tick();
                k++;
            end
            chk("inject_accept", 128'(bus.result_accept), 128'd1);
            tick();
        end
        bus.result_valid = 1'b0;
    endtask

    // one fetch episode: request/ack, optional results, then fetch_done
    task automatic fetch(input int gap, input int nres, input logic [15:0] first);
        bus.job_fetch_request = 1'b1;
        tick();
        bus.job_fetch_request = 1'b0;
        chk("fetch_ack", 128'(bus.job_fetch_ack), 128'd1);
        chk("fetch_go", 128'(bus.fetch_go), 128'd1);
        inject(nres, first);
        repeat (gap) tick();
        bus.fetch_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
        chk("fetch_complete", 128'(bus.job_fetch_complete), 128'd1);
    endtask

    task automatic finish_job();
        bus.job_complete = 1'b1;
        wait_for(W_CACK, "complete_ack_wait");
        chk("done_with_ack", 128'(bus.done), 128'd1);
        bus.job_complete = 1'b0;
        tick();
        chk("cmd_ready_after_done", 128'(bus.cmd_ready), 128'd1);
        chk("done_single", 128'(bus.done), 128'd0);
    endtask

    task automatic check_words(input string tag, input int n, input logic [15:0] first);
        chk({tag, "_nwords"}, 128'(got_q.size() - s_idx), 128'(n));
        for (int i = 0; i < n; i++) begin
            if (s_idx + i < got_q.size()) begin
                chk({tag, "_word"}, 128'(got_q[s_idx + i]), 128'(first + 16'(i)));
            end
        end
        $display("job %s: words=%0d starts=%0d fetch_go=%0d fetch_cpl=%0d cack=%0d done=%0d",
                 tag, got_q.size() - s_idx, n_start - s_start, n_go - s_go,
                 n_fcpl - s_fcpl, n_cack - s_cack, n_done - s_done);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] p;
        n_cmp = 0;
        n_err = 0;
        bus.cmd_valid = 1'b0; bus.cmd_params = '0; bus.cmd_num_results = '0;
        bus.job_accept = 1'b0; bus.job_fetch_request = 1'b0; bus.job_complete = 1'b0;
        bus.fetch_done = 1'b0; bus.result_valid = 1'b0; bus.result_data = '0;
        bus.res_ready = 1'b1;

        // ---------------- reset values ----------------
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        chk("rst_job_start", 128'(bus.job_start), 128'd0);
        chk("rst_result_accept", 128'(bus.result_accept), 128'd0);
        chk("rst_res_valid", 128'(bus.res_valid), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_errs", 128'({bus.err_timeout, bus.err_overrun}), 128'd0);
        #10 rst = 1'b1;
        tick();
        chk("post_rst_accept", 128'(bus.result_accept), 128'd1);

        // ---------------- nominal job ----------------
        snap();
        p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        send_cmd(p, 32'd4);
        chk("nom_job_start", 128'(bus.job_start), 128'd1);
        chk("nom_cmd_ready", 128'(bus.cmd_ready), 128'd0);
        chk("nom_params", bus.job_parameters, p);
        repeat (3) tick();
        accept_now();
        chk("nom_start_drop", 128'(bus.job_start), 128'd0);
        fetch(7, 2, 16'hA000);
        inject(2, 16'hA002);
        finish_job();
        chk("nom_starts", 128'(n_start - s_start), 128'd4);
        chk("nom_acks", 128'(n_ack - s_ack), 128'd1);
        chk("nom_fcpl", 128'(n_fcpl - s_fcpl), 128'd1);
        chk("nom_cack", 128'(n_cack - s_cack), 128'd1);
        chk("nom_done", 128'(n_done - s_done), 128'd1);
        chk("nom_errs", 128'({bus.err_timeout, bus.err_overrun}), 128'd0);
        check_words("nominal", 4, 16'hA000);

        // ---------------- backpressure ----------------
        snap();
        send_cmd(128'h1111, 32'd6);
        accept_now();
        fetch(0, 0, 16'h0);
        bus.res_ready    = 1'b0;
        bus.job_complete = 1'b1;
        fork
            inject(6, 16'hB000);
            begin
                tick();
                tick();
                chk("bp_accept_low", 128'(bus.result_accept), 128'd0);
                tick();
                chk("bp_res_valid", 128'(bus.res_valid), 128'd1);
                chk("bp_head", 128'(bus.res_data), 128'hB000);
                chk("bp_no_cack", 128'(bus.job_complete_ack), 128'd0);
                tick();
                tick();
                bus.res_ready = 1'b1;
            end
        join
        finish_job();
        chk("bp_ack_after_drain", 128'(ack_words - s_idx), 128'd6);
        chk("bp_cack", 128'(n_cack - s_cack), 128'd1);
        chk("bp_overrun", 128'(bus.err_overrun), 128'd0);
        check_words("backpressure", 6, 16'hB000);

        // ---------------- accept timeout ----------------
        snap();
        send_cmd(128'h2222, 32'd4);
        wait_for(W_DONE, "to_done_wait");
        chk("to_err", 128'(bus.err_timeout), 128'd1);
        chk("to_start_low", 128'(bus.job_start), 128'd0);
        chk("to_cmd_ready_low", 128'(bus.cmd_ready), 128'd0);
        tick();
        chk("to_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        chk("to_starts", 128'(n_start - s_start), 128'd8);
        chk("to_done_cnt", 128'(n_done - s_done), 128'd1);
        chk("to_no_fetch", 128'(n_go - s_go), 128'd0);

        // ---------------- overrun ----------------
        snap();
        send_cmd(128'h3333, 32'd2);
        chk("ov_timeout_cleared", 128'(bus.err_timeout), 128'd0);
        accept_now();
        fetch(1, 0, 16'h0);
        inject(2, 16'hC000);
        chk("ov_not_yet", 128'(bus.err_overrun), 128'd0);
        inject(1, 16'hC002);
        chk("ov_set", 128'(bus.err_overrun), 128'd1);
        finish_job();
        chk("ov_sticky", 128'(bus.err_overrun), 128'd1);
        check_words("overrun", 3, 16'hC000);

        // ---------------- multi-fetch with fetch/complete collision ----------------
        snap();
        send_cmd(128'h4444, 32'd1);
        chk("mf_overrun_cleared", 128'(bus.err_overrun), 128'd0);
        accept_now();
        fetch(2, 0, 16'h0);
        bus.job_complete      = 1'b1;
        bus.job_fetch_request = 1'b1;
        tick();
        bus.job_fetch_request = 1'b0;
        chk("mf_second_ack", 128'(bus.job_fetch_ack), 128'd1);
        chk("mf_no_cack", 128'(bus.job_complete_ack), 128'd0);
        inject(1, 16'hD000);
        repeat (3) tick();
        chk("mf_cack_held", 128'(n_cack - s_cack), 128'd0);
        bus.fetch_done = 1'b1;
        tick();
        bus.fetch_done = 1'b0;
        chk("mf_fcpl2", 128'(bus.job_fetch_complete), 128'd1);
        finish_job();
        chk("mf_go", 128'(n_go - s_go), 128'd2);
        chk("mf_fcpl", 128'(n_fcpl - s_fcpl), 128'd2);
        check_words("multifetch", 1, 16'hD000);

        // ---------------- zero-result job ----------------
        snap();
        send_cmd(128'h5555, 32'd0);
        accept_now();
        fetch(0, 0, 16'h0);
        finish_job();
        chk("zero_cack", 128'(n_cack - s_cack), 128'd1);
        chk("zero_errs", 128'({bus.err_timeout, bus.err_overrun}), 128'd0);
        check_words("zero", 0, 16'h0);

        // ---------------- reset in the middle of a fetch ----------------
        snap();
        p = 128'h6666_7777;
        send_cmd(p, 32'd4);
        accept_now();
        bus.job_fetch_request = 1'b1;
        tick();
        bus.job_fetch_request = 1'b0;
        bus.res_ready = 1'b0;
        inject(1, 16'hE000);
        chk("mr_buffered", 128'(bus.res_valid), 128'd1);
        #3 rst = 1'b0;
        #1;
        chk("mr_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        chk("mr_res_valid", 128'(bus.res_valid), 128'd0);
        chk("mr_job_start", 128'(bus.job_start), 128'd0);
        chk("mr_params", bus.job_parameters, 128'd0);
        chk("mr_accept", 128'(bus.result_accept), 128'd0);
        chk("mr_res_data", 128'(bus.res_data), 128'd0);
        #2 rst = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        chk("mr_ready_after", 128'(bus.cmd_ready), 128'd1);
        chk("mr_valid_after", 128'(bus.res_valid), 128'd0);
        chk("mr_accept_after", 128'(bus.result_accept), 128'd1);
        check_words("reset", 0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
